// File: rtl/uart_pkg.sv
// Shared UART constants and the drain FSM state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } drain_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W register array, synchronous write, asynchronous read.
//   clk    - system clock
//   we     - write enable
//   waddr  - write index
//   wdata  - write byte
//   raddr  - read index
//   rdata  - byte at raddr (combinational)
module uart_fifo_mem #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer between the UART receiver and transmitter. Absorbs received bytes
// while the transmitter is busy and drains them one at a time on its handshake.
//   clk, resetn   - clock, asynchronous active-low reset
//   wr_valid/data - byte strobe from the receiver
//   flush         - synchronous clear of buffered bytes
//   tx_busy       - transmitter busy
//   tx_enable     - one-cycle start strobe to the transmitter (registered)
//   tx_data       - byte presented to the transmitter (registered, held)
//   level/empty/full - fill status from the registered pointers
//   overflow      - sticky dropped-write flag, cleared by overflow_clr
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DATA_W     = UART_DATA_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_valid,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  flush,
    input  logic                  tx_busy,
    output logic                  tx_enable,
    output logic [DATA_W-1:0]     tx_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              pop;
    logic              ovf_set;
    drain_state_e      state;

    // Status from registered pointers; the extra MSB separates full from empty.
    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    // Flush beats both a same-cycle write (silently) and an IDLE pop.
    assign wr_en   = wr_valid && !full && !flush;
    assign ovf_set = wr_valid && full && !flush;
    assign pop     = (state == IDLE) && !empty && !tx_busy && !flush;

    uart_fifo_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (rd_data)
    );

    // Pointers and sticky overflow; a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= PTR_W'(0);
            rd_ptr   <= PTR_W'(0);
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Drain FSM: issue one byte, then a guard cycle covering the transmitter's
    // one-cycle lag in raising tx_busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            tx_enable <= 1'b0;
            tx_data   <= DATA_W'(0);
        end else begin
            case (state)
                IDLE: begin
                    tx_enable <= 1'b0;
                    if (pop) begin
                        tx_enable <= 1'b1;
                        tx_data   <= rd_data;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_enable <= 1'b0;
                    state     <= HOLD;
                end
                HOLD: begin
                    tx_enable <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    tx_enable <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder (DEPTH = 16, 8-bit data).
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       resetn;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       flush;
    logic       tx_busy;
    logic       tx_enable;
    logic [7:0] tx_data;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       overflow_clr;

    int tests_run = 0;
    int fails     = 0;

    logic [7:0] got_q[$];
    int         en_cyc_q[$];

    uart_tx_feeder #(
        .DEPTH_LOG2 (4),
        .DATA_W     (8)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .flush        (flush),
        .tx_busy      (tx_busy),
        .tx_enable    (tx_enable),
        .tx_data      (tx_data),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge: outputs settled, inputs safe to drive.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transmitter model: busy rises the cycle after tx_enable and lasts 10 cycles.
    task automatic run_tx_model(input int cycles);
        int busy_cnt = 0;
        logic prev_en = 1'b0;
        got_q.delete();
        en_cyc_q.delete();
        for (int c = 0; c < cycles; c++) begin
            step();
            if (prev_en) busy_cnt = 10;
            tx_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            prev_en = tx_enable;
            if (tx_enable) begin
                got_q.push_back(tx_data);
                en_cyc_q.push_back(c);
            end
        end
        tx_busy = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; flush = 1'b0;
        tx_busy = 1'b0; overflow_clr = 1'b0;
        #12;
        tests_run++; if (level !== 5'd0) begin fails++; $display("FAIL reset.level got %0d want 0", level); end
        tests_run++; if (empty !== 1'b1) begin fails++; $display("FAIL reset.empty got %b want 1", empty); end
        tests_run++; if (full !== 1'b0) begin fails++; $display("FAIL reset.full got %b want 0", full); end
        tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset.overflow got %b want 0", overflow); end
        tests_run++; if (tx_enable !== 1'b0) begin fails++; $display("FAIL reset.tx_enable got %b want 0", tx_enable); end
        tests_run++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset.tx_data got %h want 00", tx_data); end
        resetn = 1'b1;
        step();
        step();
    endtask

    task automatic test_single_byte();
        tx_busy = 1'b0;
        step();
        wr_valid = 1'b1; wr_data = 8'hA5;                      // cycle T
        step();
        wr_valid = 1'b0;                                       // cycle T+1
        tests_run++; if (tx_enable !== 1'b0) begin fails++; $display("FAIL single.en_t1 got %b want 0", tx_enable); end
        tests_run++; if (level !== 5'd1) begin fails++; $display("FAIL single.level_t1 got %0d want 1", level); end
        step();                                                // cycle T+2
        tests_run++; if (tx_enable !== 1'b1) begin fails++; $display("FAIL single.en_t2 got %b want 1", tx_enable); end
        tests_run++; if (tx_data !== 8'hA5) begin fails++; $display("FAIL single.data got %h want a5", tx_data); end
        tests_run++; if (level !== 5'd0) begin fails++; $display("FAIL single.level_t2 got %0d want 0", level); end
        tests_run++; if (empty !== 1'b1) begin fails++; $display("FAIL single.empty got %b want 1", empty); end
        step();                                                // cycle T+3
        tests_run++; if (tx_enable !== 1'b0) begin fails++; $display("FAIL single.en_t3 got %b want 0", tx_enable); end
        tests_run++; if (tx_data !== 8'hA5) begin fails++; $display("FAIL single.data_hold got %h want a5", tx_data); end
        step();
        step();
    endtask

    task automatic test_burst_busy();
        logic saw_en = 1'b0;
        tx_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (tx_enable) saw_en = 1'b1;
            wr_valid = 1'b1; wr_data = 8'(i);
        end
        step();
        wr_valid = 1'b0;
        if (tx_enable) saw_en = 1'b1;
        step();
        if (tx_enable) saw_en = 1'b1;
        tests_run++; if (level !== 5'd5) begin fails++; $display("FAIL burst.level got %0d want 5", level); end
        tests_run++; if (saw_en !== 1'b0) begin fails++; $display("FAIL burst.no_enable got %b want 0", saw_en); end
        run_tx_model(150);
        tests_run++; if (got_q.size() != 5) begin fails++; $display("FAIL burst.count got %0d want 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            tests_run++; if (got_q[i] !== 8'(i + 1)) begin fails++; $display("FAIL burst.order[%0d] got %h want %h", i, got_q[i], 8'(i + 1)); end
        end
        for (int i = 1; i < en_cyc_q.size(); i++) begin
            tests_run++; if (en_cyc_q[i] - en_cyc_q[i-1] < 11) begin fails++; $display("FAIL burst.spacing[%0d] got %0d want >=11", i, en_cyc_q[i] - en_cyc_q[i-1]); end
        end
        tests_run++; if (level !== 5'd0) begin fails++; $display("FAIL burst.level_end got %0d want 0", level); end
    endtask

    task automatic test_full_overflow();
        tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            wr_valid = 1'b1; wr_data = 8'h10 + 8'(i);
        end
        step();
        wr_valid = 1'b0;
        tests_run++; if (level !== 5'd16) begin fails++; $display("FAIL full.level got %0d want 16", level); end
        tests_run++; if (full !== 1'b1) begin fails++; $display("FAIL full.full got %b want 1", full); end
        tests_run++; if (empty !== 1'b0) begin fails++; $display("FAIL full.empty got %b want 0", empty); end
        tests_run++; if (overflow !== 1'b1) begin fails++; $display("FAIL full.overflow got %b want 1", overflow); end
        // Dropped write and clear in the same cycle: set wins.
        wr_valid = 1'b1; wr_data = 8'hEE; overflow_clr = 1'b1;
        step();
        wr_valid = 1'b0; overflow_clr = 1'b0;
        tests_run++; if (overflow !== 1'b1) begin fails++; $display("FAIL full.set_beats_clr got %b want 1", overflow); end
        tests_run++; if (level !== 5'd16) begin fails++; $display("FAIL full.level_hold got %0d want 16", level); end
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL full.clr got %b want 0", overflow); end
        run_tx_model(300);
        tests_run++; if (got_q.size() != 16) begin fails++; $display("FAIL full.drain_count got %0d want 16", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 16; i++) begin
            tests_run++; if (got_q[i] !== 8'h10 + 8'(i)) begin fails++; $display("FAIL full.drain[%0d] got %h want %h", i, got_q[i], 8'h10 + 8'(i)); end
        end
    endtask

    task automatic test_wrap();
        int wi = 0;
        got_q.delete();
        for (int c = 0; c < 400; c++) begin
            step();
            if (tx_enable) got_q.push_back(tx_data);
            tx_busy = ($urandom_range(0, 3) == 0);
            if ((c % 5 == 0) && (wi < 40)) begin
                wr_valid = 1'b1; wr_data = 8'(wi); wi++;
            end else begin
                wr_valid = 1'b0;
            end
        end
        tx_busy = 1'b0;
        tests_run++; if (got_q.size() != 40) begin fails++; $display("FAIL wrap.count got %0d want 40", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 40; i++) begin
            tests_run++; if (got_q[i] !== 8'(i)) begin fails++; $display("FAIL wrap.seq[%0d] got %h want %h", i, got_q[i], 8'(i)); end
        end
        tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL wrap.overflow got %b want 0", overflow); end
        tests_run++; if (empty !== 1'b1) begin fails++; $display("FAIL wrap.empty got %b want 1", empty); end
    endtask

    task automatic test_flush();
        int n_en = 0;
        tx_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            wr_valid = 1'b1; wr_data = 8'h31 + 8'(i);
        end
        step();
        tests_run++; if (level !== 5'd3) begin fails++; $display("FAIL flush.level_pre got %0d want 3", level); end
        wr_valid = 1'b1; wr_data = 8'h77; flush = 1'b1;
        step();
        wr_valid = 1'b0; flush = 1'b0;
        tests_run++; if (level !== 5'd0) begin fails++; $display("FAIL flush.level got %0d want 0", level); end
        tests_run++; if (empty !== 1'b1) begin fails++; $display("FAIL flush.empty got %b want 1", empty); end
        tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL flush.overflow got %b want 0", overflow); end
        tx_busy = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (tx_enable) n_en++;
        end
        tests_run++; if (n_en != 0) begin fails++; $display("FAIL flush.issued got %0d want 0", n_en); end
    endtask

    task automatic test_reset_mid_issue();
        int n_en = 0;
        tx_busy = 1'b0;
        step();
        wr_valid = 1'b1; wr_data = 8'h5A;                      // cycle T
        step();
        wr_data = 8'h5B;                                       // cycle T+1
        step();
        wr_valid = 1'b0;                                       // cycle T+2: ISSUE
        tests_run++; if (tx_enable !== 1'b1) begin fails++; $display("FAIL rst_mid.en_pre got %b want 1", tx_enable); end
        tests_run++; if (tx_data !== 8'h5A) begin fails++; $display("FAIL rst_mid.data_pre got %h want 5a", tx_data); end
        tests_run++; if (level !== 5'd1) begin fails++; $display("FAIL rst_mid.level_pre got %0d want 1", level); end
        #2;
        resetn = 1'b0;
        #1;
        tests_run++; if (tx_enable !== 1'b0) begin fails++; $display("FAIL rst_mid.en got %b want 0", tx_enable); end
        tests_run++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_mid.data got %h want 00", tx_data); end
        step();
        resetn = 1'b1;
        step();
        tests_run++; if (level !== 5'd0) begin fails++; $display("FAIL rst_mid.level got %0d want 0", level); end
        tests_run++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_mid.empty got %b want 1", empty); end
        for (int c = 0; c < 10; c++) begin
            step();
            if (tx_enable) n_en++;
        end
        tests_run++; if (n_en != 0) begin fails++; $display("FAIL rst_mid.issued got %0d want 0", n_en); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst_busy();
        test_full_overflow();
        test_wrap();
        test_flush();
        test_reset_mid_issue();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired: run exceeded its time bound");
        $fatal(1);
    end

endmodule
